load_store_unit: RTL

Memory-access stage that sits directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, runs one load or store over a simple request/acknowledge data bus, and aligns byte lanes. It sign- or zero-extends load data and returns a single-cycle completion pulse, with misalignment and bus-timeout status, to the writeback/control logic.

---
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one load or store on a req/ack bus, aligns byte lanes,
// extends load data and reports misalignment and bus timeout with a done pulse.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_request,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_REQUEST = 2'b01,
        S_DONE    = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic        r_is_load;
    logic [31:0] r_count;
    logic        r_done;
    logic        r_misaligned;
    logic        r_bus_error;
    logic [31:0] r_load_data;
    logic        r_mem_request;
    logic        r_mem_write;
    logic [31:0] r_mem_address;
    logic [3:0]  r_mem_byte_enable;
    logic [31:0] r_mem_write_data;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_timeout;
    logic [3:0]  w_byte_enable;
    logic [31:0] w_write_data;

    // Shift the addressed lane down to bit 0, then sign- or zero-extend by size.
    function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                                input logic [1:0]  offset,
                                                input logic [2:0]  f3);
        logic [31:0] shifted;
        shifted = rdata >> {offset, 3'b000};
        case (f3[1:0])
            2'b00:   extend_load = f3[2] ? {24'h000000, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   extend_load = f3[2] ? {16'h0000, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: extend_load = shifted;
        endcase
    endfunction

    assign w_accept     = start & (load ^ store);
    assign w_misaligned = (funct3[1] & (address[1:0] != 2'b00)) |
                          ((funct3[1:0] == 2'b01) & address[0]);
    // A zero timeout parameter means wait for the ack forever.
    assign w_timeout    = (TIMEOUT_CYCLES != 32'd0) && (r_count == (TIMEOUT_CYCLES - 32'd1));

    // Byte-lane enables and lane-replicated store data for the access size.
    always_comb begin
        w_byte_enable = 4'b1111;
        w_write_data  = store_data;
        case (funct3[1:0])
            2'b00: begin
                w_byte_enable = 4'b0001 << address[1:0];
                w_write_data  = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_byte_enable = 4'b0011 << address[1:0];
                w_write_data  = {2{store_data[15:0]}};
            end
            default: begin
                w_byte_enable = 4'b1111;
                w_write_data  = store_data;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_misaligned ? S_DONE : S_REQUEST;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_REQUEST: begin
                if (mem_ack || w_timeout) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_REQUEST;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operation latch, bus outputs, timeout counter and completion status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3          <= 3'b000;
            r_offset          <= 2'b00;
            r_is_load         <= 1'b0;
            r_count           <= 32'd0;
            r_done            <= 1'b0;
            r_misaligned      <= 1'b0;
            r_bus_error       <= 1'b0;
            r_load_data       <= 32'd0;
            r_mem_request     <= 1'b0;
            r_mem_write       <= 1'b0;
            r_mem_address     <= 32'd0;
            r_mem_byte_enable <= 4'b0000;
            r_mem_write_data  <= 32'd0;
        end else begin
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3  <= funct3;
                        r_offset  <= address[1:0];
                        r_is_load <= load;
                        r_count   <= 32'd0;
                        if (w_misaligned) begin
                            r_done       <= 1'b1;
                            r_misaligned <= 1'b1;
                            r_load_data  <= 32'd0;
                        end else begin
                            r_mem_request     <= 1'b1;
                            r_mem_write       <= store;
                            r_mem_address     <= {address[31:2], 2'b00};
                            r_mem_byte_enable <= w_byte_enable;
                            r_mem_write_data  <= w_write_data;
                        end
                    end
                end
                S_REQUEST: begin
                    if (mem_ack) begin
                        r_mem_request <= 1'b0;
                        r_done        <= 1'b1;
                        r_load_data   <= r_is_load ? extend_load(mem_read_data, r_offset, r_funct3)
                                                   : 32'd0;
                    end else if (w_timeout) begin
                        r_mem_request <= 1'b0;
                        r_done        <= 1'b1;
                        r_bus_error   <= 1'b1;
                        r_load_data   <= 32'd0;
                    end else begin
                        r_count <= r_count + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign load_data       = r_load_data;
    assign misaligned      = r_misaligned;
    assign bus_error       = r_bus_error;
    assign mem_request     = r_mem_request;
    assign mem_write       = r_mem_write;
    assign mem_address     = r_mem_address;
    assign mem_byte_enable = r_mem_byte_enable;
    assign mem_write_data  = r_mem_write_data;

endmodule
